// File: rtl/ppt_pulse_gen.sv
// Burst pulse generator: on a start edge emits N pulses of Wh high / Wl low cycles, then a done strobe.
// Latency: pulse_out rises the cycle after the sampled start edge; all outputs registered.
module ppt_pulse_gen #(
    parameter int CNT_W = 8,
    parameter int N_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [N_W-1:0]   cfg_count,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [N_W-1:0]   pulses_sent
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] phase, phase_nxt;
    logic [N_W-1:0]   sent_nxt;
    logic             start_d;
    logic             start_edge;
    logic             launch;

    // Effective lengths are kept in shadow form so mid-burst cfg changes are invisible.
    logic [CNT_W-1:0] wh_cfg, wl_cfg;
    logic [CNT_W-1:0] wh_sh, wl_sh;
    logic [N_W-1:0]   count_sh;

    assign start_edge = start & ~start_d;
    assign wh_cfg     = (cfg_width == '0) ? CNT_W'(1) : cfg_width;
    assign wl_cfg     = (cfg_period > cfg_width) ? (cfg_period - cfg_width) : CNT_W'(1);

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        sent_nxt  = pulses_sent;
        launch    = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: launch = start_edge;
                HIGH: begin
                    if (phase == '0) begin
                        state_nxt = LOW;
                        phase_nxt = wl_sh - CNT_W'(1);
                        sent_nxt  = pulses_sent + N_W'(1);
                    end else begin
                        phase_nxt = phase - CNT_W'(1);
                    end
                end
                LOW: begin
                    if (phase == '0) begin
                        if ((pulses_sent == count_sh) && (count_sh != '0)) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = HIGH;
                            phase_nxt = wh_sh - CNT_W'(1);
                        end
                    end else begin
                        phase_nxt = phase - CNT_W'(1);
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                    launch    = start_edge;
                end
                default: state_nxt = IDLE;
            endcase
        end
        if (launch) begin
            state_nxt = HIGH;
            phase_nxt = wh_cfg - CNT_W'(1);
            sent_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= '0;
            pulses_sent <= '0;
            start_d     <= 1'b1;
            pulse_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wh_sh       <= CNT_W'(1);
            wl_sh       <= CNT_W'(1);
            count_sh    <= '0;
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            pulses_sent <= sent_nxt;
            start_d     <= start;
            pulse_out   <= (state_nxt == HIGH);
            busy        <= (state_nxt == HIGH) || (state_nxt == LOW);
            done        <= (state_nxt == DONE);
            if (launch) begin
                wh_sh    <= wh_cfg;
                wl_sh    <= wl_cfg;
                count_sh <= cfg_count;
            end
        end
    end

endmodule

// File: tb/tb_ppt_pulse_gen.sv
// Bench for ppt_pulse_gen: per-cycle expectations from the burst timing formulas go into a scoreboard
// queue as stimulus is driven; a negedge monitor pops and compares them against the DUT outputs.
module tb_ppt_pulse_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] cfg_width;
    logic [7:0] cfg_period;
    logic [7:0] cfg_count;
    logic       pulse_out;
    logic       busy;
    logic       done;
    logic [7:0] pulses_sent;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       pulse;
        logic       busy;
        logic       done;
        logic [7:0] sent;
    } exp_t;

    exp_t sb[$];

    ppt_pulse_gen #(.CNT_W(8), .N_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .cfg_width   (cfg_width),
        .cfg_period  (cfg_period),
        .cfg_count   (cfg_count),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .pulses_sent (pulses_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("pulse_out",   32'(pulse_out),   32'(e.pulse));
            check("busy",        32'(busy),        32'(e.busy));
            check("done",        32'(done),        32'(e.done));
            check("pulses_sent", 32'(pulses_sent), 32'(e.sent));
        end
    end

    // Pulses completed by cycle c after the launch edge: the j-th pulse ends visibly in cycle wh+j*per+1.
    function automatic logic [7:0] sent_at(input int c, input int wh, input int per, input int n);
        int s;
        s = (c - 1 >= wh) ? ((c - 1 - wh) / per + 1) : 0;
        if (n != 0 && s > n) s = n;
        return 8'(s);
    endfunction

    function automatic exp_t expect_at(input int c, input int wh, input int per, input int n);
        exp_t e;
        if (n != 0 && c > n * per) begin
            e.pulse = 1'b0;
            e.busy  = 1'b0;
            e.done  = (c == n * per + 1);
        end else begin
            e.pulse = ((c - 1) % per) < wh;
            e.busy  = 1'b1;
            e.done  = 1'b0;
        end
        e.sent = sent_at(c, wh, per, n);
        return e;
    endfunction

    // Launch a burst and queue the expected outputs for ncyc cycles after the launch edge.
    // abort_c/edge2_c/wchg_c (0 = unused) pick the cycle in which abort, a second start edge
    // or a cfg_width change is driven.
    task automatic burst(input int w, input int p, input int n, input int ncyc,
                         input int abort_c, input int edge2_c, input int wchg_c);
        int   wh, wl, per;
        exp_t e;
        wh  = (w == 0) ? 1 : w;
        wl  = (p > w) ? p - w : 1;
        per = wh + wl;
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk); #1;
        cfg_width  = 8'(w);
        cfg_period = 8'(p);
        cfg_count  = 8'(n);
        start      = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            start = (c == edge2_c);
            abort = (c == abort_c);
            if (c == wchg_c) cfg_width = 8'(w + 3);
            e = expect_at(c, wh, per, n);
            if (abort_c > 0 && c > abort_c) begin
                e.pulse = 1'b0;
                e.busy  = 1'b0;
                e.done  = 1'b0;
                e.sent  = sent_at(abort_c, wh, per, n);
            end
            sb.push_back(e);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        exp_t idle_e;
        idle_e = '{pulse: 1'b0, busy: 1'b0, done: 1'b0, sent: 8'd0};
        rst_n      = 1'b0;
        start      = 1'b1;
        abort      = 1'b0;
        cfg_width  = 8'd2;
        cfg_period = 8'd5;
        cfg_count  = 8'd1;
        #12;
        check("rst_pulse_out", 32'(pulse_out),   32'd0);
        check("rst_busy",      32'(busy),        32'd0);
        check("rst_done",      32'(done),        32'd0);
        check("rst_sent",      32'(pulses_sent), 32'd0);
        #10 rst_n = 1'b1;

        // start held high through reset release must not launch
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            sb.push_back(idle_e);
        end

        burst(2, 5, 3, 18, 0, 0, 0);
        burst(0, 0, 2, 7, 0, 0, 0);
        burst(3, 4, 0, 45, 40, 0, 0);
        burst(2, 6, 2, 15, 0, 4, 3);
        burst(5, 3, 2, 15, 0, 0, 0);

        // asynchronous reset while in HIGH of the second pulse
        burst(2, 4, 3, 4, 0, 0, 0);
        @(posedge clk); #1;
        check("pre_rst_pulse", 32'(pulse_out),   32'd1);
        check("pre_rst_busy",  32'(busy),        32'd1);
        check("pre_rst_sent",  32'(pulses_sent), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pulse", 32'(pulse_out),   32'd0);
        check("async_rst_busy",  32'(busy),        32'd0);
        check("async_rst_done",  32'(done),        32'd0);
        check("async_rst_sent",  32'(pulses_sent), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        burst(1, 2, 1, 5, 0, 0, 0);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
